// File: rtl/color_mixer_pkg.sv
// Shared definitions for the colour mixer: FSM encoding, channel indices, default widths.
// The optional rounding build is selected with COLOR_MIXER_ROUND_EN.
package cm_pkg;

   localparam int N_DEFAULT = 8;
   localparam int M_DEFAULT = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SCALE = 2'b01,
      PEND  = 2'b10
   } cm_state_e;

   localparam logic [1:0] CH_R = 2'd0;
   localparam logic [1:0] CH_G = 2'd1;
   localparam logic [1:0] CH_B = 2'd2;

endpackage

// File: rtl/color_mixer_if.sv
// Sample-set bus from the ADC stage into the colour mixer (valid/ready handshake).
interface color_mixer_if
   import cm_pkg::*;
#(
   parameter int N = N_DEFAULT,
   parameter int M = M_DEFAULT
);
   logic [N-1:0] red_value;
   logic [N-1:0] green_value;
   logic [N-1:0] blue_value;
   logic [M-1:0] intensity_value;
   logic         sample_valid;
   logic         sample_ready;

   modport master (
      output red_value, green_value, blue_value, intensity_value, sample_valid,
      input  sample_ready
   );

   modport slave (
      input  red_value, green_value, blue_value, intensity_value, sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/color_mixer_shift_add_scaler.sv
// One-channel sequential shift-add multiplier: one intensity bit per step, LSB first.
// COLOR_MIXER_ROUND_EN preloads half an LSB of the result so the product rounds to nearest.
module shift_add_scaler
   import cm_pkg::*;
#(
   parameter int N = N_DEFAULT,
   parameter int M = M_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         step,
   input  logic [N-1:0] colour,
   input  logic [M-1:0] intensity,
   output logic         done,
   output logic [N-1:0] result
);
   localparam int AW = N + M;
   localparam int BW = (M > 1) ? $clog2(M) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(M - 1);
   localparam logic [BW-1:0] BIT_ONE  = {{(BW-1){1'b0}}, 1'b1};
`ifdef COLOR_MIXER_ROUND_EN
   localparam logic [AW-1:0] PRELOAD = {{(N+1){1'b0}}, 1'b1, {(M-1){1'b0}}};
`else
   localparam logic [AW-1:0] PRELOAD = {AW{1'b0}};
`endif

   logic [AW-1:0] acc_r;
   logic [AW-1:0] addend_s;
   logic [AW-1:0] sum_s;
   logic [BW-1:0] bit_r;

   // Partial product for the current intensity bit and the running sum.
   always_comb begin
      addend_s = {AW{1'b0}};
      if (intensity[bit_r]) begin
         addend_s = {{M{1'b0}}, colour} << bit_r;
      end else begin
         addend_s = {AW{1'b0}};
      end
      sum_s  = acc_r + addend_s;
      done   = step && (bit_r == BIT_LAST);
      result = sum_s[AW-1:M];
   end

   // Accumulator and bit index; the last step re-arms for the next channel.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r <= {AW{1'b0}};
         bit_r <= {BW{1'b0}};
      end else if (start) begin
         acc_r <= PRELOAD;
         bit_r <= {BW{1'b0}};
      end else if (step) begin
         if (bit_r == BIT_LAST) begin
            acc_r <= PRELOAD;
            bit_r <= {BW{1'b0}};
         end else begin
            acc_r <= sum_s;
            bit_r <= bit_r + BIT_ONE;
         end
      end else begin
         acc_r <= acc_r;
         bit_r <= bit_r;
      end
   end
endmodule

// File: rtl/color_mixer.sv
// Colour mixer: scales RGB codes by intensity and drives three double-buffered LED PWMs.
// Build with COLOR_MIXER_ROUND_EN for rounded (instead of truncated) scaling.
module color_mixer
   import cm_pkg::*;
#(
   parameter int N = N_DEFAULT,
   parameter int M = M_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   color_mixer_if.slave  smp,
   output logic          pwm_r,
   output logic          pwm_g,
   output logic          pwm_b,
   output logic          period_start,
   output logic          update_done
);
   localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
   localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

   cm_state_e    state_r, next_state_s;
   logic [1:0]   ch_r;
   logic [N-1:0] red_code_r, green_code_r, blue_code_r;
   logic [M-1:0] int_code_r;
   logic [N-1:0] pend_red_r, pend_green_r, pend_blue_r;
   logic [N-1:0] act_red_r, act_green_r, act_blue_r;
   logic [N-1:0] cnt_r;
   logic         pwm_red_r, pwm_green_r, pwm_blue_r, upd_r;
   logic         sample_ready_s, capture_s, step_s, commit_s;
   logic         scl_done_s;
   logic [N-1:0] scl_result_s, colour_s;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    next_state_s = smp.sample_valid ? SCALE : IDLE;
         SCALE:   next_state_s = (scl_done_s && (ch_r == CH_B)) ? PEND : SCALE;
         PEND:    next_state_s = commit_s ? IDLE : PEND;
         default: next_state_s = IDLE;
      endcase
   end

   // State-decoded controls; commit only happens while pending at the period's last count.
   always_comb begin
      sample_ready_s = 1'b0;
      capture_s      = 1'b0;
      step_s         = 1'b0;
      commit_s       = 1'b0;
      case (state_r)
         IDLE: begin
            sample_ready_s = 1'b1;
            capture_s      = smp.sample_valid;
         end
         SCALE:   step_s   = 1'b1;
         PEND:    commit_s = (cnt_r == CNT_MAX);
         default: sample_ready_s = 1'b0;
      endcase
   end

   // Channel select for the shared multiplier.
   always_comb begin
      colour_s = {N{1'b0}};
      case (ch_r)
         CH_R:    colour_s = red_code_r;
         CH_G:    colour_s = green_code_r;
         CH_B:    colour_s = blue_code_r;
         default: colour_s = {N{1'b0}};
      endcase
   end

   shift_add_scaler #(.N(N), .M(M)) u_scaler (
      .clk       (clk),
      .reset     (reset),
      .start     (capture_s),
      .step      (step_s),
      .colour    (colour_s),
      .intensity (int_code_r),
      .done      (scl_done_s),
      .result    (scl_result_s)
   );

   // Sample capture, channel sequencing and pending-duty buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         ch_r         <= CH_R;
         red_code_r   <= {N{1'b0}};
         green_code_r <= {N{1'b0}};
         blue_code_r  <= {N{1'b0}};
         int_code_r   <= {M{1'b0}};
         pend_red_r   <= {N{1'b0}};
         pend_green_r <= {N{1'b0}};
         pend_blue_r  <= {N{1'b0}};
      end else begin
         if (capture_s) begin
            ch_r         <= CH_R;
            red_code_r   <= smp.red_value;
            green_code_r <= smp.green_value;
            blue_code_r  <= smp.blue_value;
            int_code_r   <= smp.intensity_value;
         end
         if (scl_done_s) begin
            case (ch_r)
               CH_R:    pend_red_r   <= scl_result_s;
               CH_G:    pend_green_r <= scl_result_s;
               CH_B:    pend_blue_r  <= scl_result_s;
               default: pend_red_r   <= pend_red_r;
            endcase
            ch_r <= ch_r + 2'd1;
         end
      end
   end

   // Free-running PWM counter, active duties and registered compare outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r       <= {N{1'b0}};
         act_red_r   <= {N{1'b0}};
         act_green_r <= {N{1'b0}};
         act_blue_r  <= {N{1'b0}};
         pwm_red_r   <= 1'b0;
         pwm_green_r <= 1'b0;
         pwm_blue_r  <= 1'b0;
         upd_r       <= 1'b0;
      end else begin
         cnt_r <= cnt_r + CNT_ONE;
         if (commit_s) begin
            act_red_r   <= pend_red_r;
            act_green_r <= pend_green_r;
            act_blue_r  <= pend_blue_r;
         end
         upd_r       <= commit_s;
         pwm_red_r   <= (cnt_r < act_red_r);
         pwm_green_r <= (cnt_r < act_green_r);
         pwm_blue_r  <= (cnt_r < act_blue_r);
      end
   end

   assign smp.sample_ready = sample_ready_s;
   assign period_start     = (cnt_r == {N{1'b0}});
   assign update_done      = upd_r;
   assign pwm_r            = pwm_red_r;
   assign pwm_g            = pwm_green_r;
   assign pwm_b            = pwm_blue_r;
endmodule

// File: tb/tb_color_mixer.sv
// Directed bench for color_mixer: duty counts per PWM period against hand-computed values.
module tb_color_mixer;
   import cm_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic pwm_r, pwm_g, pwm_b, period_start, update_done;
   int   checks = 0;
   int   errors = 0;

   color_mixer_if #(.N(8), .M(6)) smp ();

   color_mixer dut (
      .clk          (clk),
      .reset        (reset),
      .smp          (smp),
      .pwm_r        (pwm_r),
      .pwm_g        (pwm_g),
      .pwm_b        (pwm_b),
      .period_start (period_start),
      .update_done  (update_done)
   );

   always #5 clk = ~clk;

   task automatic apply_sample(input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input logic [5:0] i);
      @(negedge clk);
      smp.red_value       = r;
      smp.green_value     = g;
      smp.blue_value      = b;
      smp.intensity_value = i;
      smp.sample_valid    = 1'b1;
      @(negedge clk);
      smp.sample_valid    = 1'b0;
   endtask

   // Returns the number of cycles waited for update_done, or -1 on timeout.
   task automatic wait_update(output int cyc);
      cyc = -1;
      for (int i = 0; i < 600; i++) begin
         if (update_done === 1'b1) begin
            cyc = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic count_period(output int cr, output int cg, output int cb, output int cu);
      cr = 0; cg = 0; cb = 0; cu = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         cr += int'(pwm_r);
         cg += int'(pwm_g);
         cb += int'(pwm_b);
         cu += int'(update_done);
      end
   endtask

   task automatic test_reset;
      int first, gap, cr, cg, cb, cu;
      reset = 1'b1;
      smp.sample_valid = 1'b0;
      smp.red_value = 8'd0; smp.green_value = 8'd0; smp.blue_value = 8'd0;
      smp.intensity_value = 6'd0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (smp.sample_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b expected 1", smp.sample_ready);
      end
      checks++;
      if ({pwm_r, pwm_g, pwm_b} !== 3'b000) begin
         errors++; $display("FAIL reset_pwm: got %b expected 000", {pwm_r, pwm_g, pwm_b});
      end
      checks++;
      if (update_done !== 1'b0) begin
         errors++; $display("FAIL reset_update_done: got %b expected 0", update_done);
      end
      checks++;
      if (period_start !== 1'b0) begin
         errors++; $display("FAIL reset_period_start: got %b expected 0 (counter 1)", period_start);
      end
      first = -1; gap = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (period_start === 1'b1) begin first = i; break; end
      end
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (period_start === 1'b1) begin gap = i; break; end
      end
      checks++;
      if (first < 0 || gap != 256) begin
         errors++; $display("FAIL period_gap: got %0d expected 256 (first %0d)", gap, first);
      end
      count_period(cr, cg, cb, cu);
      checks++;
      if (cr != 0 || cg != 0 || cb != 0 || cu != 0) begin
         errors++; $display("FAIL idle_outputs: got r%0d g%0d b%0d u%0d expected all 0", cr, cg, cb, cu);
      end
   endtask

   task automatic test_main;
      int cyc, cr, cg, cb, cu, eg;
`ifdef COLOR_MIXER_ROUND_EN
      eg = 128;
`else
      eg = 127;
`endif
      apply_sample(8'd200, 8'd255, 8'd0, 6'd32);
      checks++;
      if (smp.sample_ready !== 1'b0) begin
         errors++; $display("FAIL main_ready_scale: got %b expected 0", smp.sample_ready);
      end
      wait_update(cyc);
      checks++;
      if (cyc < 19 || cyc > 274) begin
         errors++; $display("FAIL main_latency: got %0d expected 19..274", cyc);
      end
      checks++;
      if (period_start !== 1'b1) begin
         errors++; $display("FAIL main_commit_at_zero: got %b expected 1", period_start);
      end
      count_period(cr, cg, cb, cu);
      checks++;
      if (cr != 100 || cg != eg || cb != 0) begin
         errors++; $display("FAIL main_duty: got r%0d g%0d b%0d expected r100 g%0d b0", cr, cg, cb, eg);
      end
      checks++;
      if (cu != 0) begin
         errors++; $display("FAIL main_single_update: got %0d extra pulses expected 0", cu);
      end
   endtask

   task automatic test_full_and_zero;
      int cyc, cr, cg, cb, cu;
      apply_sample(8'd255, 8'd255, 8'd255, 6'd63);
      wait_update(cyc);
      count_period(cr, cg, cb, cu);
      checks++;
      if (cyc < 0 || cr != 251 || cg != 251 || cb != 251) begin
         errors++; $display("FAIL full_duty: got r%0d g%0d b%0d (wait %0d) expected 251 each", cr, cg, cb, cyc);
      end
      apply_sample(8'd255, 8'd255, 8'd255, 6'd0);
      wait_update(cyc);
      count_period(cr, cg, cb, cu);
      checks++;
      if (cyc < 0 || cr != 0 || cg != 0 || cb != 0) begin
         errors++; $display("FAIL zero_intensity: got r%0d g%0d b%0d (wait %0d) expected 0 each", cr, cg, cb, cyc);
      end
   endtask

   task automatic test_round;
      int cyc, cr, cg, cb, cu, er;
`ifdef COLOR_MIXER_ROUND_EN
      er = 2;
`else
      er = 1;
`endif
      apply_sample(8'd3, 8'd0, 8'd0, 6'd32);
      wait_update(cyc);
      count_period(cr, cg, cb, cu);
      checks++;
      if (cyc < 0 || cr != er || cg != 0 || cb != 0) begin
         errors++; $display("FAIL round_small: got r%0d g%0d b%0d expected r%0d g0 b0", cr, cg, cb, er);
      end
      apply_sample(8'd0, 8'd255, 8'd0, 6'd63);
      wait_update(cyc);
      count_period(cr, cg, cb, cu);
      checks++;
      if (cyc < 0 || cr != 0 || cg != 251 || cb != 0) begin
         errors++; $display("FAIL round_large: got r%0d g%0d b%0d expected r0 g251 b0", cr, cg, cb);
      end
   endtask

   task automatic test_ignore;
      int cyc, cr, cg, cb, cu;
      apply_sample(8'd64, 8'd128, 8'd192, 6'd32);
      repeat (4) @(negedge clk);
      smp.red_value = 8'd255; smp.green_value = 8'd255; smp.blue_value = 8'd255;
      smp.intensity_value = 6'd63;
      smp.sample_valid = 1'b1;
      checks++;
      if (smp.sample_ready !== 1'b0) begin
         errors++; $display("FAIL ignore_ready_scale: got %b expected 0", smp.sample_ready);
      end
      @(negedge clk);
      smp.sample_valid = 1'b0;
      repeat (13) @(negedge clk);
      smp.sample_valid = 1'b1;
      checks++;
      if (smp.sample_ready !== 1'b0) begin
         errors++; $display("FAIL ignore_ready_pend: got %b expected 0", smp.sample_ready);
      end
      @(negedge clk);
      smp.sample_valid = 1'b0;
      wait_update(cyc);
      count_period(cr, cg, cb, cu);
      checks++;
      if (cyc < 0 || cr != 32 || cg != 64 || cb != 96) begin
         errors++; $display("FAIL ignore_duty: got r%0d g%0d b%0d expected r32 g64 b96", cr, cg, cb);
      end
      apply_sample(8'd0, 8'd64, 8'd0, 6'd32);
      wait_update(cyc);
      count_period(cr, cg, cb, cu);
      checks++;
      if (cyc < 0 || cr != 0 || cg != 32 || cb != 0) begin
         errors++; $display("FAIL after_ignore_duty: got r%0d g%0d b%0d expected r0 g32 b0", cr, cg, cb);
      end
   endtask

   task automatic test_reset_mid_scale;
      int cyc, cr, cg, cb, cu;
      apply_sample(8'd255, 8'd255, 8'd255, 6'd63);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (smp.sample_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_ready: got %b expected 1", smp.sample_ready);
      end
      wait_update(cyc);
      checks++;
      if (cyc != -1) begin
         errors++; $display("FAIL midreset_no_commit: got update after %0d cycles expected none", cyc);
      end
      count_period(cr, cg, cb, cu);
      checks++;
      if (cr != 0 || cg != 0 || cb != 0) begin
         errors++; $display("FAIL midreset_duty: got r%0d g%0d b%0d expected 0 each", cr, cg, cb);
      end
      apply_sample(8'd128, 8'd64, 8'd0, 6'd63);
      wait_update(cyc);
      checks++;
      if (cyc < 19 || cyc > 274) begin
         errors++; $display("FAIL midreset_latency: got %0d expected 19..274", cyc);
      end
      count_period(cr, cg, cb, cu);
      checks++;
      if (cr != 126 || cg != 63 || cb != 0) begin
         errors++; $display("FAIL midreset_next_duty: got r%0d g%0d b%0d expected r126 g63 b0", cr, cg, cb);
      end
   endtask

   initial begin
      test_reset();
      test_main();
      test_full_and_zero();
      test_round();
      test_ignore();
      test_reset_mid_scale();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/color_mixer.md
Name: color_mixer

Overview:
Downstream consumer of the four-channel ADC stage. It accepts one converted sample set: 8-bit red, green and blue codes plus a 6-bit intensity code. It scales each colour by intensity with a sequential shift-add multiplier and drives three LED PWM outputs. New duty cycles are double-buffered and commit only at a PWM period boundary, so no glitched or partial periods occur.

Parameters:
N, 8, colour code width and PWM counter width (period = 2^N clocks)
M, 6, intensity code width (multiplier iterations per channel)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
red_value  input  N  red ADC code
green_value  input  N  green ADC code
blue_value  input  N  blue ADC code
intensity_value  input  M  intensity ADC code
sample_valid  input  1  sample set valid this cycle
sample_ready  output  1  block can accept a sample (high only in IDLE)
pwm_r  output  1  red LED drive
pwm_g  output  1  green LED drive
pwm_b  output  1  blue LED drive
period_start  output  1  one-cycle pulse when PWM counter == 0
update_done  output  1  one-cycle pulse on the cycle new duties commit

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: state IDLE; PWM counter = 0; active, pending and working registers = 0; pwm_* = 0; update_done = 0. Reset mid-SCALE or mid-PEND abandons the sample with no commit.
- sample_ready is combinational: 1 iff state == IDLE. This includes the cycle immediately after reset release.
- Capture: sample_valid && sample_ready on a rising edge registers all four inputs. State goes to SCALE with channel index 0 and bit index 0. sample_valid outside IDLE is ignored and nothing is queued.
- SCALE: one intensity bit per cycle, LSB first. The accumulator adds (colour << bit) when intensity bit = 1. Channel order is R, G, B, M cycles each, 3*M cycles total (18 at the default).
  - Accumulator width is N+M.
  - result = (colour * intensity) >> M, truncated to N bits. It never overflows, since intensity is at most 2^M-1.
  - The final cycle loads the pending registers, and state goes to PEND.
- PEND: waits until PWM counter == 2^N-1. On that edge, active <= pending, update_done pulses on the following cycle (counter == 0), and state goes to IDLE.
  - PEND entered on the exact cycle the counter is 2^N-1 still waits a full period, because the commit test occurs in PEND only.
- PWM: free-running N-bit counter, 0 to 2^N-1, wraps to 0.
  - pwm_x = registered (counter < active_x).
  - Duty 0 keeps the output low forever; duty 2^N-1 gives high for 255 of 256 clocks.
  - period_start = (counter == 0), combinational.
- Latency from capture edge to first PWM period with new duty: 3*M+1 cycles minimum, 3*M+2^N cycles maximum.
- Active duties are unchanged throughout SCALE and PEND.

Optional Feature:
COLOR_MIXER_ROUND_EN:
- Defined: the accumulator is preloaded with 2^(M-1) before each channel, so result = (colour*intensity + 2^(M-1)) >> M, rounded to nearest with ties up.
- Undefined: preload is 0 and the result is truncated.
- Cycle timing is identical in both builds.

Decomposition:
- Package cm_pkg holds:
  - state encoding: IDLE = 2'b00, SCALE = 2'b01, PEND = 2'b10
  - channel index constants: CH_R = 0, CH_G = 1, CH_B = 2
  - default widths N = 8, M = 6
- One sub-module, shift_add_scaler: a one-channel sequential shift-add multiply with start, done, operands, result and the optional round preload.
- The top instantiates shift_add_scaler once and time-multiplexes it across channels. PWM counter, compare logic and FSM stay in color_mixer.

Test Plan:
1. Reset held 5 cycles, then released -> pwm_* = 0, sample_ready = 1 on the first post-reset cycle, period_start pulses every 256 cycles.
2. R=200, G=255, B=0, I=32, valid pulse -> commit at next counter wrap. Red is high 100 clocks per period, green 127, blue never high. update_done pulses once at counter 0.
3. R=G=B=255, I=63 -> duty 251 on all channels. I=0 -> all outputs stay low.
4. R=3, I=32 -> duty 1 without COLOR_MIXER_ROUND_EN, duty 2 with it. G=255, I=63 -> 251 in both builds.
5. Second sample_valid during SCALE and during PEND -> ignored, sample_ready = 0. A new sample after return to IDLE commits at the following wrap.
6. Reset asserted on SCALE cycle 10 -> no commit, active duties = 0, state IDLE. Next sample processes normally with full 3*M scaling.
